// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Active-high a..g patterns (seg[6]=a .. seg[0]=g) for hex digits 0-F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to a..g segment pattern (active-high).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern_c
);

  assign pattern_c = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with dead-time gap and tear-free frame loads.
// Optional SEG7_LZ_BLANK_EN: blank digits above the most significant nonzero nibble.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS   = 4,
  parameter int unsigned PRESCALE   = 1000,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*N_DIGITS-1:0] load_data,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an
);

  localparam int unsigned CNT_W = $clog2(PRESCALE);
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned DAT_W = 4 * N_DIGITS;

  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(PRESCALE - 2);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [6:0]          SEG_POL  = {7{ACTIVE_LOW}};
  localparam logic [N_DIGITS-1:0] AN_POL   = {N_DIGITS{ACTIVE_LOW}};

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [DAT_W-1:0]    display;
  logic [DAT_W-1:0]    pending;
  logic                pending_full;

  logic [3:0]          nibble_c;
  logic [6:0]          pattern_c;
  logic                show_c;
  logic                boundary_c;
  logic                accept_c;

  assign load_ready = ~pending_full;
  assign accept_c   = load_valid & ~pending_full;
  assign boundary_c = (state == GAP) && (idx == IDX_LAST) && enable;

  // Select the nibble of the digit currently being scanned.
  always_comb begin
    nibble_c = 4'h0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (IDX_W'(i) == idx) nibble_c = display[4*i +: 4];
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  logic [IDX_W-1:0] msd_c;

  // Most significant nonzero digit; digit 0 counts as significant even when zero.
  always_comb begin
    msd_c = '0;
    for (int i = 1; i < int'(N_DIGITS); i++) begin
      if (display[4*i +: 4] != 4'h0) msd_c = IDX_W'(i);
    end
  end

  assign show_c = (idx <= msd_c);
`else
  assign show_c = 1'b1;
`endif

  seg7_hex_decode u_decode (
    .nibble    (nibble_c),
    .pattern_c (pattern_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      display      <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      seg          <= SEG_OFF ^ SEG_POL;
      an           <= AN_POL;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (enable) state <= DRIVE;
        end
        DRIVE: begin
          if (!enable) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= GAP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          cnt <= '0;
          if (!enable) begin
            state <= IDLE;
            idx   <= '0;
          end else begin
            state <= DRIVE;
            idx   <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          idx   <= '0;
        end
      endcase

      // Pending word moves to the display only between frames (or while idle).
      if (pending_full && (boundary_c || state == IDLE)) begin
        display      <= pending;
        pending_full <= 1'b0;
      end
      if (accept_c) begin
        pending      <= load_data;
        pending_full <= 1'b1;
      end

      // Blank immediately when enable drops rather than finishing the slot.
      if (state == DRIVE && enable) begin
        an  <= (N_DIGITS'(1) << idx) ^ AN_POL;
        seg <= (show_c ? pattern_c : SEG_OFF) ^ SEG_POL;
      end else begin
        an  <= AN_POL;
        seg <= SEG_OFF ^ SEG_POL;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (N_DIGITS=4, PRESCALE=4) plus an ACTIVE_LOW instance.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [6:0]  seg;
  logic [3:0]  an;

  logic        enable_b;
  logic        load_valid_b;
  logic        load_ready_b;
  logic [15:0] load_data_b;
  logic [6:0]  seg_b;
  logic [3:0]  an_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.N_DIGITS(4), .PRESCALE(4), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load_valid(load_valid),
    .load_ready(load_ready), .load_data(load_data), .seg(seg), .an(an)
  );

  seg7_scan_driver #(.N_DIGITS(4), .PRESCALE(4), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .reset(reset), .enable(enable_b), .load_valid(load_valid_b),
    .load_ready(load_ready_b), .load_data(load_data_b), .seg(seg_b), .an(an_b)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance until dut's an goes 0000 -> 0001 (first cycle of digit 0).
  task automatic wait_frame_start();
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev = an;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1);
      if (prev == 4'b0000 && an == 4'b0001) found = 1'b1;
      prev = an;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL frame_start: timeout, an=%b required 0001 after 0000", an);
    end
  endtask

  task automatic load_word(input logic [15:0] d);
    bit ok;
    ok = 1'b0;
    load_valid = 1'b1;
    load_data  = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (load_ready) ok = 1'b1;
      else step(1);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL load_ready_wait: timeout, load_ready=%b required 1", load_ready);
    end
    step(1);
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; load_valid = 1'b0; load_data = '0;
    enable_b = 1'b0; load_valid_b = 1'b0; load_data_b = '0;
    step(2);
    checks++; if (seg !== 7'h00) begin errors++; $display("FAIL reset_seg: got %h required 00", seg); end
    checks++; if (an !== 4'b0000) begin errors++; $display("FAIL reset_an: got %b required 0000", an); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", load_ready); end
    checks++; if (seg_b !== 7'h7F) begin errors++; $display("FAIL reset_seg_al: got %h required 7f", seg_b); end
    checks++; if (an_b !== 4'b1111) begin errors++; $display("FAIL reset_an_al: got %b required 1111", an_b); end
    reset = 1'b0;
    step(3);
    checks++; if (an !== 4'b0000 || seg !== 7'h00) begin errors++; $display("FAIL idle_off: got an=%b seg=%h required 0000/00", an, seg); end
  endtask

  task automatic test_scan();
    load_word(16'h12AF);
    step(1);
    enable = 1'b1;
    wait_frame_start();
    for (int k = 0; k < 3; k++) begin
      checks++; if (an !== 4'b0001 || seg !== 7'h47) begin errors++; $display("FAIL scan_d0_c%0d: got an=%b seg=%h required 0001/47", k, an, seg); end
      step(1);
    end
    checks++; if (an !== 4'b0000 || seg !== 7'h00) begin errors++; $display("FAIL scan_gap0: got an=%b seg=%h required 0000/00", an, seg); end
    step(1);
    checks++; if (an !== 4'b0010 || seg !== 7'h77) begin errors++; $display("FAIL scan_d1: got an=%b seg=%h required 0010/77", an, seg); end
    step(4);
    checks++; if (an !== 4'b0100 || seg !== 7'h6D) begin errors++; $display("FAIL scan_d2: got an=%b seg=%h required 0100/6d", an, seg); end
    step(4);
    checks++; if (an !== 4'b1000 || seg !== 7'h30) begin errors++; $display("FAIL scan_d3: got an=%b seg=%h required 1000/30", an, seg); end
    step(3);
    checks++; if (an !== 4'b0000) begin errors++; $display("FAIL scan_gap3: got an=%b required 0000", an); end
    step(1);
    checks++; if (an !== 4'b0001 || seg !== 7'h47) begin errors++; $display("FAIL scan_period: got an=%b seg=%h required 0001/47", an, seg); end
  endtask

  task automatic test_tearfree();
    int n;
    step(5);
    load_valid = 1'b1;
    load_data  = 16'h1111;
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL tf_ready_first: got %b required 1", load_ready); end
    step(1);
    load_data = 16'h2222;
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL tf_ready_full: got %b required 0", load_ready); end
    checks++; if (an !== 4'b0010 || seg !== 7'h77) begin errors++; $display("FAIL tf_old_frame: got an=%b seg=%h required 0010/77", an, seg); end
    n = 0;
    while (load_ready !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    checks++; if (n != 9) begin errors++; $display("FAIL tf_ready_at_boundary: got %0d cycles required 9", n); end
    checks++; if (an !== 4'b0000) begin errors++; $display("FAIL tf_boundary_gap: got an=%b required 0000", an); end
    step(1);
    load_valid = 1'b0;
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL tf_second_accept: got ready=%b required 0", load_ready); end
    for (int d = 0; d < 4; d++) begin
      checks++; if (an !== 4'(1 << d) || seg !== 7'h30) begin errors++; $display("FAIL tf_frame1_d%0d: got an=%b seg=%h required %b/30", d, an, seg, 4'(1 << d)); end
      step(4);
    end
    for (int d = 0; d < 4; d++) begin
      checks++; if (an !== 4'(1 << d) || seg !== 7'h6D) begin errors++; $display("FAIL tf_frame2_d%0d: got an=%b seg=%h required %b/6d", d, an, seg, 4'(1 << d)); end
      if (d < 3) step(4);
    end
  endtask

  task automatic test_enable();
    wait_frame_start();
    step(8);
    checks++; if (an !== 4'b0100 || seg !== 7'h6D) begin errors++; $display("FAIL en_d2: got an=%b seg=%h required 0100/6d", an, seg); end
    enable = 1'b0;
    step(1);
    checks++; if (an !== 4'b0000 || seg !== 7'h00) begin errors++; $display("FAIL en_drop: got an=%b seg=%h required 0000/00", an, seg); end
    step(3);
    checks++; if (an !== 4'b0000) begin errors++; $display("FAIL en_hold: got an=%b required 0000", an); end
    enable = 1'b1;
    step(1);
    checks++; if (an !== 4'b0000) begin errors++; $display("FAIL en_restart_lag: got an=%b required 0000", an); end
    step(1);
    checks++; if (an !== 4'b0001 || seg !== 7'h6D) begin errors++; $display("FAIL en_restart_d0: got an=%b seg=%h required 0001/6d", an, seg); end
  endtask

  task automatic test_reset_mid_drive();
    load_valid = 1'b1;
    load_data  = 16'h3333;
    step(1);
    load_valid = 1'b0;
    checks++; if (load_ready !== 1'b0 || an !== 4'b0001) begin errors++; $display("FAIL rst_pre: got ready=%b an=%b required 0/0001", load_ready, an); end
    reset = 1'b1;
    #1;
    checks++; if (seg !== 7'h00 || an !== 4'b0000) begin errors++; $display("FAIL rst_async: got an=%b seg=%h required 0000/00", an, seg); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", load_ready); end
    step(1);
    reset = 1'b0;
    step(1);
    checks++; if (an !== 4'b0000) begin errors++; $display("FAIL rst_idle: got an=%b required 0000", an); end
    step(1);
    checks++; if (an !== 4'b0001 || seg !== 7'h7E) begin errors++; $display("FAIL rst_cleared: got an=%b seg=%h required 0001/7e", an, seg); end
    wait_frame_start();
    checks++; if (seg !== 7'h7E) begin errors++; $display("FAIL rst_discard: got seg=%h required 7e", seg); end
  endtask

  task automatic test_lz();
    logic [6:0] hi;
`ifdef SEG7_LZ_BLANK_EN
    hi = 7'h00;
`else
    hi = 7'h7E;
`endif
    load_word(16'h0050);
    wait_frame_start();
    wait_frame_start();
    checks++; if (seg !== 7'h7E) begin errors++; $display("FAIL lz_d0: got %h required 7e", seg); end
    step(4);
    checks++; if (seg !== 7'h5B) begin errors++; $display("FAIL lz_d1: got %h required 5b", seg); end
    step(4);
    checks++; if (an !== 4'b0100 || seg !== hi) begin errors++; $display("FAIL lz_d2: got an=%b seg=%h required 0100/%h", an, seg, hi); end
    step(4);
    checks++; if (an !== 4'b1000 || seg !== hi) begin errors++; $display("FAIL lz_d3: got an=%b seg=%h required 1000/%h", an, seg, hi); end
  endtask

  task automatic test_active_low();
    bit found;
    load_valid_b = 1'b1;
    load_data_b  = 16'h0008;
    step(1);
    load_valid_b = 1'b0;
    step(1);
    enable_b = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1);
      if (an_b == 4'b1110) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL al_d0_wait: timeout, an=%b required 1110", an_b); end
    checks++; if (seg_b !== 7'h00) begin errors++; $display("FAIL al_d0_seg: got %h required 00", seg_b); end
    checks++; if (load_ready_b !== 1'b1) begin errors++; $display("FAIL al_ready: got %b required 1", load_ready_b); end
    step(3);
    checks++; if (an_b !== 4'b1111 || seg_b !== 7'h7F) begin errors++; $display("FAIL al_gap: got an=%b seg=%h required 1111/7f", an_b, seg_b); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tearfree();
    test_enable();
    test_reset_mid_drive();
    test_lz();
    test_active_low();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
